// File: rtl/sbp_lookup_pipe.sv
// Pipelined unibit-trie longest-prefix lookup: one BRAM + compare pair per key bit, valid/tag shift
// register beside the chain, and a table-write port on BRAM port B with an optional drain-first mode.
module sbp_lookup_pipe #(
    parameter int NUM_STAGES    = 32,
    parameter int KEY_BITS      = 32,
    parameter int ADDR_BITS     = 11,
    parameter int DATA_BITS     = 64,
    parameter int STAGE_ID_BITS = 6,
    parameter int LOCATION_BITS = 11,
    parameter int TAG_BITS      = 8,
    parameter int STAGE_LAT     = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   key_valid_i,
    output logic                                   key_ready_o,
    input  logic [KEY_BITS-1:0]                    key_i,
    input  logic [TAG_BITS-1:0]                    tag_i,
    output logic                                   res_valid_o,
    output logic [LOCATION_BITS+STAGE_ID_BITS-1:0] res_o,
    output logic [TAG_BITS-1:0]                    res_tag_o,
    input  logic                                   upd_valid_i,
    output logic                                   upd_ready_o,
    input  logic                                   upd_sync_i,
    input  logic [STAGE_ID_BITS-1:0]               upd_stage_i,
    input  logic [ADDR_BITS-1:0]                   upd_addr_i,
    input  logic [DATA_BITS-1:0]                   upd_data_i,
    output logic                                   upd_done_o,
    output logic                                   upd_err_o,
    output logic                                   busy_o
);
    localparam int L       = NUM_STAGES * STAGE_LAT;
    localparam int CNT_W   = $clog2(L + 1);
    localparam int RES_W   = LOCATION_BITS + STAGE_ID_BITS;
    localparam int HIT_BIT = ADDR_BITS + LOCATION_BITS;
    localparam int EXTRA   = L - 2 * NUM_STAGES;
    localparam int DEPTH   = 1 << ADDR_BITS;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_WRITE, S_DONE} state_t;

    state_t                   r_state;
    logic                     r_key_ready;
    logic                     r_upd_ready;
    logic                     r_upd_done;
    logic                     r_upd_err;
    logic [STAGE_ID_BITS-1:0] r_upd_stage;
    logic [ADDR_BITS-1:0]     r_upd_addr;
    logic [DATA_BITS-1:0]     r_upd_data;
    logic [CNT_W-1:0]         r_cnt;
    logic [L-1:0]             r_vld_sr;
    logic [TAG_BITS-1:0]      r_tag_sr [L];

    logic                     w_accept;
    logic                     w_res_vld;
    logic [RES_W-1:0]         w_res_final;

    logic [NUM_STAGES-1:0][KEY_BITS-1:0]  w_key_out;
    logic [NUM_STAGES-1:0][RES_W-1:0]     w_best_out;
    logic [NUM_STAGES-1:0][ADDR_BITS-1:0] w_ptr_out;
    logic                                 w_unused_tail;

    // Child pointer of the previous level plus the key bit of this level selects the trie node.
    function automatic logic [ADDR_BITS-1:0] stage_addr(input logic [ADDR_BITS-1:0] ptr,
                                                        input logic key_bit);
        return ptr + ADDR_BITS'(key_bit);
    endfunction

    assign w_accept      = key_valid_i & r_key_ready;
    assign w_res_vld     = r_vld_sr[L-1];
    assign w_unused_tail = ^{w_key_out[NUM_STAGES-1], w_ptr_out[NUM_STAGES-1]};

    assign key_ready_o = r_key_ready;
    assign upd_ready_o = r_upd_ready;
    assign upd_done_o  = r_upd_done;
    assign upd_err_o   = r_upd_err;
    assign busy_o      = (r_cnt != '0);
    assign res_valid_o = w_res_vld;
    assign res_o       = w_res_vld ? w_res_final : '0;
    assign res_tag_o   = w_res_vld ? r_tag_sr[L-1] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_sr <= '0;
            for (int i = 0; i < L; i++) r_tag_sr[i] <= '0;
            r_cnt <= '0;
        end else begin
            r_vld_sr    <= {r_vld_sr[L-2:0], w_accept};
            r_tag_sr[0] <= w_accept ? tag_i : '0;
            for (int i = 1; i < L; i++) r_tag_sr[i] <= r_tag_sr[i-1];
            case ({w_accept, w_res_vld})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_key_ready <= 1'b1;
            r_upd_ready <= 1'b1;
            r_upd_done  <= 1'b0;
            r_upd_err   <= 1'b0;
        end else begin
            r_upd_done <= 1'b0;
            r_upd_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (upd_valid_i) begin
                        r_upd_stage <= upd_stage_i;
                        r_upd_addr  <= upd_addr_i;
                        r_upd_data  <= upd_data_i;
                        if (int'(upd_stage_i) >= NUM_STAGES) begin
                            r_upd_err <= 1'b1;
                        end else if (upd_sync_i) begin
                            r_state     <= S_DRAIN;
                            r_key_ready <= 1'b0;
                            r_upd_ready <= 1'b0;
                        end else begin
                            r_state     <= S_WRITE;
                            r_upd_ready <= 1'b0;
                        end
                    end
                end
                // A key accepted alongside the update is already counted here, so it drains too.
                S_DRAIN: begin
                    if (r_cnt == '0) r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_state     <= S_DONE;
                    r_upd_done  <= 1'b1;
                    r_key_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_upd_ready <= 1'b1;
                end
            endcase
        end
    end

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        localparam int KB = KEY_BITS - 1 - (s % KEY_BITS);
        localparam logic [STAGE_ID_BITS-1:0] SID = STAGE_ID_BITS'(s);

        logic [KEY_BITS-1:0]  w_key_in;
        logic [RES_W-1:0]     w_best_in;
        logic [ADDR_BITS-1:0] w_ptr_in;
        logic                 w_b_wr;
        logic [DATA_BITS-1:0] r_mem [DEPTH];
        logic [DATA_BITS-1:0] r_rdata_p0;
        logic [KEY_BITS-1:0]  r_key_p0;
        logic [RES_W-1:0]     r_best_p0;
        logic [KEY_BITS-1:0]  r_key_p1;
        logic [RES_W-1:0]     r_best_p1;
        logic [ADDR_BITS-1:0] r_ptr_p1;

        if (s == 0) begin : g_first
            assign w_key_in  = key_i;
            assign w_best_in = '0;
            assign w_ptr_in  = '0;
        end else begin : g_chain
            assign w_key_in  = w_key_out[s-1];
            assign w_best_in = w_best_out[s-1];
            assign w_ptr_in  = w_ptr_out[s-1];
        end

        if (DATA_BITS > HIT_BIT + 1) begin : g_hi
            logic w_unused_hi;
            assign w_unused_hi = ^r_rdata_p0[DATA_BITS-1:HIT_BIT+1];
        end

        assign w_b_wr        = (r_state == S_WRITE) && (r_upd_stage == SID);
        assign w_key_out[s]  = r_key_p1;
        assign w_best_out[s] = r_best_p1;
        assign w_ptr_out[s]  = r_ptr_p1;

        // Port B write and port A read in separate processes: a same-cycle read returns the old word.
        always_ff @(posedge clk) begin
            if (w_b_wr) r_mem[r_upd_addr] <= r_upd_data;
        end

        // p0: BRAM read
        always_ff @(posedge clk) begin
            r_rdata_p0 <= r_mem[stage_addr(w_ptr_in, w_key_in[KB])];
            r_key_p0   <= w_key_in;
            r_best_p0  <= w_best_in;
        end

        // p1: hit compare, deepest hit wins
        always_ff @(posedge clk) begin
            r_key_p1  <= r_key_p0;
            r_best_p1 <= r_rdata_p0[HIT_BIT] ? {r_rdata_p0[HIT_BIT-1:ADDR_BITS], SID} : r_best_p0;
            r_ptr_p1  <= r_rdata_p0[ADDR_BITS-1:0];
        end
    end

    if (EXTRA > 0) begin : g_pad
        logic [RES_W-1:0] r_pad [EXTRA];
        always_ff @(posedge clk) begin
            r_pad[0] <= w_best_out[NUM_STAGES-1];
            for (int i = 1; i < EXTRA; i++) r_pad[i] <= r_pad[i-1];
        end
        assign w_res_final = r_pad[EXTRA-1];
    end else begin : g_nopad
        assign w_res_final = w_best_out[NUM_STAGES-1];
    end

endmodule

// File: tb/tb_sbp_lookup_pipe.sv
// Directed bench for sbp_lookup_pipe: tables loaded through the update port, then lookup, streaming,
// sync/non-sync updates, out-of-range stage and reset-during-drain scenarios.
module tb_sbp_lookup_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid_i;
    logic        key_ready_o;
    logic [31:0] key_i;
    logic [7:0]  tag_i;
    logic        res_valid_o;
    logic [16:0] res_o;
    logic [7:0]  res_tag_o;
    logic        upd_valid_i;
    logic        upd_ready_o;
    logic        upd_sync_i;
    logic [5:0]  upd_stage_i;
    logic [10:0] upd_addr_i;
    logic [63:0] upd_data_i;
    logic        upd_done_o;
    logic        upd_err_o;
    logic        busy_o;

    always #5 clk = ~clk;

    sbp_lookup_pipe dut (
        .clk(clk), .rst(rst),
        .key_valid_i(key_valid_i), .key_ready_o(key_ready_o), .key_i(key_i), .tag_i(tag_i),
        .res_valid_o(res_valid_o), .res_o(res_o), .res_tag_o(res_tag_o),
        .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o), .upd_sync_i(upd_sync_i),
        .upd_stage_i(upd_stage_i), .upd_addr_i(upd_addr_i), .upd_data_i(upd_data_i),
        .upd_done_o(upd_done_o), .upd_err_o(upd_err_o), .busy_o(busy_o)
    );

    typedef struct {
        logic [16:0] res;
        logic [7:0]  tag;
        int          cyc;
    } ent_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          n_done = 0;
    int          n_err = 0;
    int          n_stall = 0;
    ent_t        exp_q[$];
    ent_t        got_q[$];
    logic [63:0] shadow [int];
    logic [16:0] last_res;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (res_valid_o) got_q.push_back('{res: res_o, tag: res_tag_o, cyc: cyc});
        if (upd_done_o) n_done++;
        if (upd_err_o) n_err++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] mkword(input bit hit, input logic [10:0] loc, input logic [10:0] child);
        return {41'd0, hit, loc, child};
    endfunction

    // Sequential trie walk over the shadow table: deepest hit along the key's path wins.
    function automatic logic [16:0] model_lookup(input logic [31:0] key);
        logic [10:0] ptr;
        logic [10:0] a;
        logic [16:0] best;
        logic [63:0] w;
        ptr  = '0;
        best = '0;
        for (int s = 0; s < 32; s++) begin
            a = ptr + {10'd0, key[31-s]};
            w = shadow.exists(s * 4096 + int'(a)) ? shadow[s * 4096 + int'(a)] : 64'd0;
            if (w[22]) best = {w[21:11], 6'(s)};
            ptr = w[10:0];
        end
        return best;
    endfunction

    task automatic send_key(input logic [31:0] key, input logic [7:0] tag);
        int w;
        key_valid_i = 1'b1;
        key_i       = key;
        tag_i       = tag;
        w           = 0;
        while (!key_ready_o && w < 300) begin
            n_stall++;
            @(negedge clk);
            w++;
        end
        if (w >= 300) check_eq("key_accept_timeout", 64'(w), 64'd0);
        @(posedge clk);
        exp_q.push_back('{res: model_lookup(key), tag: tag, cyc: cyc});
        @(negedge clk);
        key_valid_i = 1'b0;
    endtask

    task automatic do_update(input logic [5:0] stage, input logic [10:0] addr, input logic [63:0] data,
                             input logic sync, output int lat, output int kr);
        int w;
        upd_valid_i = 1'b1;
        upd_stage_i = stage;
        upd_addr_i  = addr;
        upd_data_i  = data;
        upd_sync_i  = sync;
        w           = 0;
        while (!upd_ready_o && w < 300) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        upd_valid_i = 1'b0;
        lat = 1;
        kr  = 0;
        while (!(upd_done_o || upd_err_o) && lat < 400) begin
            if (key_ready_o) kr++;
            @(negedge clk);
            lat++;
        end
        if (lat >= 400) check_eq("upd_timeout", 64'(lat), 64'd0);
        if (upd_done_o && int'(stage) < 32) shadow[int'(stage) * 4096 + int'(addr)] = data;
        @(negedge clk);
    endtask

    task automatic check_results(input string name);
        int w;
        int n;
        w = 0;
        while (got_q.size() < exp_q.size() && w < 400) begin
            @(negedge clk);
            w++;
        end
        repeat (4) @(negedge clk);
        check_eq({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_res%0d", name, i), 64'(got_q[i].res), 64'(exp_q[i].res));
            check_eq($sformatf("%s_tag%0d", name, i), 64'(got_q[i].tag), 64'(exp_q[i].tag));
            check_eq($sformatf("%s_lat%0d", name, i), 64'(got_q[i].cyc - exp_q[i].cyc), 64'd64);
        end
        if (n > 0) last_res = got_q[n-1].res;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_res_valid"}, 64'(res_valid_o), 64'd0);
        check_eq({pfx, "_res"},       64'(res_o),       64'd0);
        check_eq({pfx, "_res_tag"},   64'(res_tag_o),   64'd0);
        check_eq({pfx, "_upd_done"},  64'(upd_done_o),  64'd0);
        check_eq({pfx, "_upd_err"},   64'(upd_err_o),   64'd0);
        check_eq({pfx, "_busy"},      64'(busy_o),      64'd0);
        check_eq({pfx, "_key_ready"}, 64'(key_ready_o), 64'd1);
        check_eq({pfx, "_upd_ready"}, 64'(upd_ready_o), 64'd1);
    endtask

    initial begin
        int lat;
        int kr;
        int d0;
        int e0;
        int s0;
        rst = 1'b1;
        key_valid_i = 1'b0; key_i = '0; tag_i = '0;
        upd_valid_i = 1'b0; upd_sync_i = 1'b0; upd_stage_i = '0; upd_addr_i = '0; upd_data_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);

        // Table load: both children of every level, stage 2 node 0 points at 4, stage 4 node 1 hits 0x123.
        for (int s = 0; s < 32; s++) begin
            do_update(6'(s), 11'd0, (s == 2) ? mkword(0, 11'h0, 11'd4) : 64'd0, 1'b0, lat, kr);
            do_update(6'(s), 11'd1, (s == 4) ? mkword(1, 11'h123, 11'd0) : 64'd0, 1'b0, lat, kr);
        end
        do_update(6'd3, 11'd4, 64'd0, 1'b0, lat, kr);
        do_update(6'd3, 11'd5, 64'd0, 1'b0, lat, kr);
        check_eq("init_done_count", 64'(n_done), 64'd66);

        // Single lookup: path 0,0,0 -> stage3 node 4 -> stage4 node 1 hit.
        send_key(32'h0A00_0001, 8'h11);
        check_eq("t1_busy", 64'(busy_o), 64'd1);
        check_results("t1");
        check_eq("t1_res_hand", 64'(last_res), 64'h48C4);

        // Back-to-back stream.
        for (int i = 0; i < 64; i++) send_key({6'(i), 2'b10, 16'h0, 8'(i)}, 8'(i));
        check_results("t2");
        check_eq("t2_busy_after", 64'(busy_o), 64'd0);

        // Sync update with 12 in flight, last key presented alongside the update.
        d0 = n_done;
        for (int i = 0; i < 11; i++) send_key((i == 5) ? 32'h1000_0000 : 32'h0300_0000 * i, 8'(8'h80 + i));
        fork
            send_key(32'h0A00_0001, 8'h8B);
            do_update(6'd3, 11'h005, mkword(1, 11'h2AA, 11'd0), 1'b1, lat, kr);
        join
        check_eq("t3_done_lat", 64'(lat), 64'd67);
        check_eq("t3_key_ready_in_drain", 64'(kr), 64'd0);
        check_results("t3");
        check_eq("t3_done_once", 64'(n_done - d0), 64'd1);
        send_key(32'h1000_0000, 8'h3C);
        check_results("t3_new");
        check_eq("t3_new_hand", 64'(last_res), 64'hAA83);

        // Non-sync update while streaming.
        d0 = n_done;
        s0 = n_stall;
        fork
            for (int i = 0; i < 20; i++) send_key(32'h0910_0001 * i, 8'(8'h40 + i));
            begin
                repeat (5) @(negedge clk);
                do_update(6'd10, 11'h100, mkword(1, 11'h077, 11'd0), 1'b0, lat, kr);
            end
        join
        check_eq("t4_done_lat", 64'(lat), 64'd2);
        check_eq("t4_no_stall", 64'(n_stall - s0), 64'd0);
        check_results("t4");
        check_eq("t4_done_once", 64'(n_done - d0), 64'd1);

        // Out-of-range stage.
        d0 = n_done;
        e0 = n_err;
        do_update(6'd40, 11'd0, mkword(1, 11'h3FF, 11'd0), 1'b0, lat, kr);
        repeat (2) @(negedge clk);
        check_eq("t5_err_lat", 64'(lat), 64'd1);
        check_eq("t5_err_once", 64'(n_err - e0), 64'd1);
        check_eq("t5_no_done", 64'(n_done - d0), 64'd0);
        check_eq("t5_upd_ready", 64'(upd_ready_o), 64'd1);
        send_key(32'h0000_0000, 8'h55);
        check_results("t5");
        check_eq("t5_hand", 64'(last_res), 64'h0);

        // Reset while draining with 5 in flight.
        d0 = n_done;
        for (int i = 0; i < 5; i++) send_key(32'h0000_0000, 8'(8'hA0 + i));
        upd_valid_i = 1'b1; upd_sync_i = 1'b1; upd_stage_i = 6'd5; upd_addr_i = 11'd0;
        upd_data_i  = mkword(1, 11'h155, 11'd0);
        @(posedge clk);
        @(negedge clk);
        upd_valid_i = 1'b0;
        @(negedge clk);
        check_eq("t6_in_drain", 64'(key_ready_o), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("t6");
        rst = 1'b0;
        exp_q.delete();
        repeat (80) @(negedge clk);
        check_eq("t6_no_results", 64'(got_q.size()), 64'd0);
        check_eq("t6_no_done", 64'(n_done - d0), 64'd0);
        send_key(32'h0000_0000, 8'h66);
        check_results("t6_after");
        check_eq("t6_no_write", 64'(last_res), 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
